regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the datapath. It provides NUM_RD independent registered read ports and one write port, with optional write-to-read bypass and an optional hardwired zero register. After reset, and on request, a built-in clear sequencer walks the array and zeroes every entry. The decode stage uses it as the general-purpose register bank.

## Interface
- DATA_W, 16: word width in bits.
- DEPTH, 16: number of entries; must be a power of two and at least 2.
- NUM_RD, 3: number of read ports, 1..8.
- ZERO_REG, 0: when 1, entry 0 always reads 0 and writes to it are dropped.
- AW is derived as clog2(DEPTH); it is not a user parameter.

- clk  in  1  clock; all logic updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clr  in  1  one-cycle pulse that starts a full array clear.
- ready  out  1  high when the array accepts reads and writes.
- rd_en  in  1  read strobe shared by all read ports.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  packed registered read data.
- rd_valid  out  1  rd_data is valid this cycle.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  DATA_W  write data.

## Operation
- State machine has two states, CLEAR and READY.
- CLEAR:
  - A clr_addr counter writes 0 to entry[clr_addr] each cycle, then increments.
  - At clr_addr == DEPTH-1 the state goes to READY and clr_addr returns to 0.
  - ready = 0; rd_en, wr_en and clr are ignored.
- READY:
  - ready = 1.
  - clr = 1 moves the state to CLEAR. Any wr_en or rd_en in that same cycle is ignored.
- Reads in READY: with rd_en = 1, every port i captures entry[rd_addr_i] into rd_data_i, and rd_valid goes high on the next cycle.
- Reads with rd_en = 0 or outside READY: rd_data holds its last value and rd_valid = 0.
- Writes in READY: wr_en = 1 writes entry[wr_addr] <= wr_data.
- Simultaneous read and write are both performed in the same cycle; there is no read-over-write priority.
- Several read ports may hit the same address; each gets the same data.
- ZERO_REG = 1: a read of address 0 returns 0 and a write to address 0 is dropped. This also applies to bypass.

## Timing
- Reset state: state = CLEAR, clr_addr = 0, ready = 0, rd_valid = 0, rd_data = 0. Array contents are undefined until the clear completes.
- The first rising edge with rst_n = 1 clears entry 0.
- ready rises after exactly DEPTH rising edges with rst_n high.
- A reset in the middle of a clear restarts the walk from entry 0.
- A clr pulse taken in READY causes ready to fall on the next cycle. ready returns DEPTH cycles after that.
- Read latency is 1 cycle: address at edge N, data and rd_valid after edge N+1.
- Write-then-read of the same address on consecutive cycles returns the new data.
- clr_addr wraps modulo DEPTH and never indexes out of range.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read that matches wr_addr while wr_en = 1 in the same READY cycle returns wr_data (write-first).
  - Each port compares its address independently.
- REGFILE_BYPASS_EN undefined:
  - The same read returns the old entry contents (read-first).
  - The write still lands in the same cycle.

## Structure
- regfile_pkg holds:
  - the rf_state_t enum (CLEAR, READY);
  - a clog2-based AW helper function;
  - the default DATA_W and DEPTH constants.
- One sub-module, regfile_clr_seq, holds the state machine and the clr_addr counter. It outputs ready, clr_we and clr_addr.
- The top level muxes clear writes and user writes into the array. It also holds the NUM_RD read-port generate loop and the bypass compare.

## Test plan
- Reset and clear, DEPTH = 16:
  - Hold rst_n = 0 for 3 cycles, then release.
  - Required: ready = 0 for 16 edges, then 1.
  - Required: reads of all 16 entries with NUM_RD = 3 return 0x0000.
- Write and parallel read:
  - Write 0xBEEF to 5 and 0x1234 to 9, then read ports (5, 9, 5).
  - Required: one cycle later rd_data = (0xBEEF, 0x1234, 0xBEEF) and rd_valid = 1.
- Same-cycle read and write:
  - Entry 3 holds 0x1111; write 0x2222 to 3 while reading 3.
  - Required with the macro: 0x2222. Required without it: 0x1111.
  - Required in both builds: the next read returns 0x2222.
- Runtime clr:
  - Assert clr with wr_en = 1 to address 7.
  - Required: ready falls for 16 cycles, the write is lost, and entry 7 reads 0 afterwards.
- Reset mid-clear:
  - Assert rst_n = 0 at clear cycle 8.
  - Required: ready rises 16 edges after release, not 8.
- ZERO_REG = 1:
  - Write 0xFFFF to 0, then read it.
  - Required: rd_data = 0, including in the same-cycle bypass case.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int DEPTH_DEF  = 16;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } rf_state_t;

   function automatic int rf_aw(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Read/write/clear bundle between a register-file client (master) and the register file (slave).
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int AW     = rf_aw(DEPTH_DEF),
   parameter int NUM_RD = 3
) ();

   logic                     clr;
   logic                     ready;
   logic                     rd_en;
   logic [NUM_RD*AW-1:0]     rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic                     rd_valid;
   logic                     wr_en;
   logic [AW-1:0]            wr_addr;
   logic [DATA_W-1:0]        wr_data;

   modport master (
      output clr, rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  ready, rd_data, rd_valid
   );

   modport slave (
      input  clr, rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output ready, rd_data, rd_valid
   );

endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every entry writing zero after reset or a clr pulse, then reports ready.
module regfile_clr_seq
   import regfile_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = rf_aw(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   output logic          ready,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);

   rf_state_t     state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      ready   = 1'b0;
      clr_we  = 1'b0;
      case (state_q)
         CLEAR: begin
            clr_we = 1'b1;
            if (addr_q == AW'(DEPTH - 1)) begin
               state_d = READY;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end
         READY: begin
            ready = 1'b1;
            if (clr) begin
               state_d = CLEAR;
               addr_d  = '0;
            end
         end
         default: begin
            state_d = CLEAR;
            addr_d  = '0;
         end
      endcase
   end

   assign clr_addr = addr_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports (1-cycle latency), one write port, self-clearing.
// REGFILE_BYPASS_EN selects write-first same-cycle reads; otherwise reads are read-first.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int NUM_RD   = 3,
   parameter int ZERO_REG = 0
) (
   input  logic      clk,
   input  logic      rst_n,
   regfile_if.slave  bus
);

   localparam int AW = rf_aw(DEPTH);

   logic                     ready;
   logic                     clr_we;
   logic [AW-1:0]            clr_addr;
   logic                     user_ok;
   logic                     wr_zero;
   logic [DATA_W-1:0]        mem [DEPTH];
   logic [NUM_RD*DATA_W-1:0] rd_next;

   regfile_clr_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clr_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (bus.clr),
      .ready    (ready),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign bus.ready = ready;

   // A clr pulse accepted in READY swallows any user access in the same cycle.
   assign user_ok = ready & ~bus.clr;
   assign wr_zero = (ZERO_REG != 0) && (bus.wr_addr == '0);

   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else if (user_ok && bus.wr_en && !wr_zero) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] nxt;

      assign addr = bus.rd_addr[i*AW +: AW];

      always_comb begin
         nxt = mem[addr];
`ifdef REGFILE_BYPASS_EN
         if (bus.wr_en && (bus.wr_addr == addr)) nxt = bus.wr_data;
`endif
         // The hardwired zero wins over the bypass path as well.
         if ((ZERO_REG != 0) && (addr == '0)) nxt = '0;
      end

      assign rd_next[i*DATA_W +: DATA_W] = nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
      end else begin
         bus.rd_valid <= user_ok & bus.rd_en;
         if (user_ok && bus.rd_en) bus.rd_data <= rd_next;
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: clear walk, parallel reads, bypass, runtime clear, mid-clear reset, zero register.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   int   n;
   logic [15:0] exp_sc;

   always #5 clk = ~clk;

   regfile_if #(.DATA_W(16), .AW(4), .NUM_RD(3)) bus ();
   regfile_if #(.DATA_W(16), .AW(4), .NUM_RD(3)) bz ();

   regfile_mp #(.DATA_W(16), .DEPTH(16), .NUM_RD(3), .ZERO_REG(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   regfile_mp #(.DATA_W(16), .DEPTH(16), .NUM_RD(3), .ZERO_REG(1)) dut_z (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bz)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd3(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
      bus.rd_en   = 1'b1;
      bus.rd_addr = {a2, a1, a0};
      step();
      bus.rd_en   = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      step();
      bus.wr_en   = 1'b0;
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (!bus.ready && cnt < 64) begin
         step();
         cnt++;
      end
   endtask

   initial begin
`ifdef REGFILE_BYPASS_EN
      exp_sc = 16'h2222;
`else
      exp_sc = 16'h1111;
`endif
      rst_n = 1'b0;
      bus.clr = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bz.clr = 1'b0; bz.rd_en = 1'b0; bz.rd_addr = '0;
      bz.wr_en = 1'b0; bz.wr_addr = '0; bz.wr_data = '0;

      repeat (3) step();
      chk("rst_ready", bus.ready, 0);
      chk("rst_valid", bus.rd_valid, 0);
      chk("rst_data", bus.rd_data, 0);

      rst_n = 1'b1;
      wait_ready(n);
      chk("clear_edges", n, 16);
      chk("z_ready", bz.ready, 1);

      for (int a = 0; a < 16; a += 3) begin
         rd3(4'(a), 4'((a + 1) % 16), 4'((a + 2) % 16));
         chk("init_zero", {bus.rd_valid, bus.rd_data}, {1'b1, 48'h0});
      end

      wr(4'd5, 16'hBEEF);
      wr(4'd9, 16'h1234);
      rd3(4'd5, 4'd9, 4'd5);
      chk("par_rd", bus.rd_data, 48'hBEEF_1234_BEEF);
      chk("par_valid", bus.rd_valid, 1);
      step();
      chk("idle_valid", bus.rd_valid, 0);
      chk("idle_hold", bus.rd_data, 48'hBEEF_1234_BEEF);

      wr(4'd3, 16'h1111);
      rd3(4'd3, 4'd3, 4'd3);
      chk("wr_then_rd", bus.rd_data, 48'h1111_1111_1111);

      bus.wr_en = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 16'h2222;
      bus.rd_en = 1'b1; bus.rd_addr = {4'd3, 4'd5, 4'd3};
      step();
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      chk("same_cycle", bus.rd_data, {exp_sc, 16'hBEEF, exp_sc});
      rd3(4'd3, 4'd3, 4'd3);
      chk("after_same", bus.rd_data, 48'h2222_2222_2222);

      wr(4'd7, 16'h7777);
      rd3(4'd7, 4'd7, 4'd7);
      chk("pre_clr", bus.rd_data, 48'h7777_7777_7777);

      bus.clr = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 16'hABCD;
      bus.rd_en = 1'b1; bus.rd_addr = {4'd7, 4'd7, 4'd7};
      step();
      bus.clr = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      chk("clr_ready_fall", bus.ready, 0);
      chk("clr_rd_ignored", bus.rd_valid, 0);
      chk("clr_rd_hold", bus.rd_data, 48'h7777_7777_7777);
      wait_ready(n);
      chk("clr_edges", n, 16);
      rd3(4'd7, 4'd5, 4'd9);
      chk("post_clr", bus.rd_data, 0);

      wr(4'd2, 16'h4242);
      rd3(4'd2, 4'd2, 4'd2);
      chk("pre_midrst", bus.rd_data, 48'h4242_4242_4242);
      bus.clr = 1'b1;
      step();
      bus.clr = 1'b0;
      repeat (7) step();
      rst_n = 1'b0;
      step();
      chk("midrst_ready", bus.ready, 0);
      chk("midrst_data", bus.rd_data, 0);
      rst_n = 1'b1;
      wait_ready(n);
      chk("midrst_edges", n, 16);

      bz.wr_en = 1'b1; bz.wr_addr = 4'd0; bz.wr_data = 16'hFFFF;
      step();
      bz.wr_addr = 4'd1; bz.wr_data = 16'h5A5A;
      step();
      bz.wr_en = 1'b0;
      bz.rd_en = 1'b1; bz.rd_addr = {4'd0, 4'd1, 4'd0};
      step();
      bz.rd_en = 1'b0;
      chk("z_rd0", bz.rd_data, 48'h0000_5A5A_0000);
      chk("z_valid", bz.rd_valid, 1);

      bz.wr_en = 1'b1; bz.wr_addr = 4'd0; bz.wr_data = 16'hFFFF;
      bz.rd_en = 1'b1; bz.rd_addr = {4'd0, 4'd0, 4'd1};
      step();
      bz.wr_en = 1'b0; bz.rd_en = 1'b0;
      chk("z_bypass", bz.rd_data, 48'h0000_0000_5A5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
